// File: rtl/core_mem_arb_if.sv
// core_mem_arb_if: core request channels and shared memory port seen by the arbiter
interface core_mem_arb_if;
    logic        i_req_val;
    logic [31:0] i_req_addr;
    logic        i_req_ack;
    logic [31:0] i_ack_rdata;
    logic        d_req_val;
    logic [31:0] d_req_addr;
    logic [2:0]  d_req_cop;
    logic [31:0] d_req_wdata;
    logic [2:0]  d_req_size;
    logic        d_req_ack;
    logic [31:0] d_ack_rdata;
    logic        m_req_val;
    logic [31:0] m_req_addr;
    logic [2:0]  m_req_cop;
    logic [31:0] m_req_wdata;
    logic [2:0]  m_req_size;
    logic        m_req_rdy;
    logic        m_resp_val;
    logic [31:0] m_resp_rdata;
    logic        err;

    modport master (
        input  i_req_val, i_req_addr,
        input  d_req_val, d_req_addr, d_req_cop, d_req_wdata, d_req_size,
        input  m_req_rdy, m_resp_val, m_resp_rdata,
        output i_req_ack, i_ack_rdata, d_req_ack, d_ack_rdata,
        output m_req_val, m_req_addr, m_req_cop, m_req_wdata, m_req_size,
        output err
    );

    modport slave (
        output i_req_val, i_req_addr,
        output d_req_val, d_req_addr, d_req_cop, d_req_wdata, d_req_size,
        output m_req_rdy, m_resp_val, m_resp_rdata,
        input  i_req_ack, i_ack_rdata, d_req_ack, d_ack_rdata,
        input  m_req_val, m_req_addr, m_req_cop, m_req_wdata, m_req_size,
        input  err
    );
endinterface

// File: rtl/core_mem_arb.sv
// core_mem_arb: merges instruction and data channels onto one memory port, one outstanding transaction
module core_mem_arb #(
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    core_mem_arb_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, ACK} state_t;

    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam bit          TMO_EN     = TIMEOUT_CYCLES != 0;

    state_t      state, state_nx;
    logic [3:0]  starve_cnt;
    logic [15:0] tmo_cnt;
    logic        grant_i;
    logic        any_req, pick_i, tmo_hit, done;

    assign any_req = bus.i_req_val | bus.d_req_val;
    assign pick_i  = bus.i_req_val & (~bus.d_req_val | (starve_cnt == STARVE_LIM));
    assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);
    assign done    = bus.m_resp_val | tmo_hit;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: one transaction walks IDLE -> REQ -> RESP -> ACK -> IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_req ? REQ : IDLE;
            REQ:     state_nx = bus.m_req_rdy ? RESP : REQ;
            RESP:    state_nx = done ? ACK : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs, grant, starvation and timeout bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.m_req_val   <= 1'b0;
            bus.m_req_addr  <= '0;
            bus.m_req_cop   <= '0;
            bus.m_req_wdata <= '0;
            bus.m_req_size  <= '0;
            bus.i_req_ack   <= 1'b0;
            bus.i_ack_rdata <= '0;
            bus.d_req_ack   <= 1'b0;
            bus.d_ack_rdata <= '0;
            bus.err         <= 1'b0;
            grant_i         <= 1'b0;
            starve_cnt      <= '0;
            tmo_cnt         <= '0;
        end else begin
            bus.i_req_ack <= 1'b0;
            bus.d_req_ack <= 1'b0;
            if (state == IDLE && any_req) begin
                grant_i         <= pick_i;
                bus.m_req_val   <= 1'b1;
                bus.m_req_addr  <= pick_i ? bus.i_req_addr : bus.d_req_addr;
                bus.m_req_cop   <= pick_i ? 3'b000 : bus.d_req_cop;
                bus.m_req_wdata <= pick_i ? 32'h0 : bus.d_req_wdata;
                bus.m_req_size  <= pick_i ? 3'b010 : bus.d_req_size;
                starve_cnt      <= (pick_i || !bus.i_req_val) ? 4'd0 :
                                   (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
            end
            if (state == REQ && bus.m_req_rdy) begin
                bus.m_req_val <= 1'b0;
                tmo_cnt       <= '0;
            end
            if (state == RESP) begin
                tmo_cnt <= tmo_cnt + 16'd1;
                if (done) begin
                    if (grant_i) begin
                        bus.i_req_ack   <= 1'b1;
                        bus.i_ack_rdata <= bus.m_resp_val ? bus.m_resp_rdata : 32'h0;
                    end else begin
                        bus.d_req_ack   <= 1'b1;
                        bus.d_ack_rdata <= bus.m_resp_val ? bus.m_resp_rdata : 32'h0;
                    end
                    if (!bus.m_resp_val) bus.err <= 1'b1;
                end
            end
        end
    end
endmodule
